// File: rtl/mul_datapath_if.sv
// ---------------------------------------------------------------------------
// mul_datapath_if
// Bundles the operand bus, the control strobes coming from the multiplier
// control FSM, the eqz status going back to it, and the result
// valid/ready handshake toward the downstream consumer.
//
// Signals
//   data_in       operand bus (WIDTH)
//   ldA, ldB      load operand A / operand B from data_in
//   ldP           accumulate: P <= P + A
//   clr_p         clear the accumulator
//   decre         decrement the B counter
//   done          product complete, capture P into the holding register
//   eqz           B counter is zero
//   result        held product (2*WIDTH)
//   result_valid  result holds an unconsumed product
//   result_ready  downstream accepts the result
//   overrun       sticky flag: a product was overwritten before acceptance
//
// Modports
//   master  controller / consumer side (drives strobes and result_ready)
//   slave   datapath side
// ---------------------------------------------------------------------------
interface mul_datapath_if #(
    parameter int WIDTH = 16
);

    logic [WIDTH-1:0]   data_in;
    logic               ldA;
    logic               ldB;
    logic               ldP;
    logic               clr_p;
    logic               decre;
    logic               done;
    logic               eqz;
    logic [2*WIDTH-1:0] result;
    logic               result_valid;
    logic               result_ready;
    logic               overrun;

    modport master (
        output data_in,
        output ldA,
        output ldB,
        output ldP,
        output clr_p,
        output decre,
        output done,
        output result_ready,
        input  eqz,
        input  result,
        input  result_valid,
        input  overrun
    );

    modport slave (
        input  data_in,
        input  ldA,
        input  ldB,
        input  ldP,
        input  clr_p,
        input  decre,
        input  done,
        input  result_ready,
        output eqz,
        output result,
        output result_valid,
        output overrun
    );

endinterface

// File: rtl/mul_datapath.sv
// ---------------------------------------------------------------------------
// mul_datapath
// Datapath of the repeated-addition multiplier. Operand A is held, operand B
// counts down, and P accumulates A once per iteration so that P = A*B when B
// reaches zero. eqz goes back to the control FSM combinationally. On done the
// product is captured into a holding register that is handed downstream with
// a valid/ready handshake; an unconsumed product that gets overwritten sets a
// sticky overrun flag.
//
// Ports
//   clk    clock, all state changes on the rising edge
//   reset  asynchronous, active-high; clears every register
//   bus    mul_datapath_if.slave (operand bus, strobes, eqz, result handshake)
//
// Parameters
//   WIDTH  operand width; accumulator and result are 2*WIDTH bits
// ---------------------------------------------------------------------------
module mul_datapath #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    mul_datapath_if.slave  bus
);

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] p_reg;
    logic [2*WIDTH-1:0] result_reg;
    logic               valid_reg;
    logic               overrun_reg;
    logic               b_is_zero;
    logic               transfer;

    // B == 0 is needed both by the FSM (same-cycle decision, so no register
    // in between) and by the decrement saturation below.
    assign b_is_zero = (b_reg == '0);

    // A handshake completes on any edge where the held product is valid and
    // the consumer is ready.
    assign transfer = valid_reg && bus.result_ready;

    // Operand A only ever changes on an explicit load; it is independent of
    // every other strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg <= '0;
        end else if (bus.ldA) begin
            a_reg <= bus.data_in;
        end
    end

    // The B counter: a load takes priority over a decrement, and a decrement
    // at zero saturates so that a stray decre can never wrap to all-ones and
    // restart a huge iteration count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_reg <= '0;
        end else if (bus.ldB) begin
            b_reg <= bus.data_in;
        end else if (bus.decre && !b_is_zero) begin
            b_reg <= b_reg - WIDTH'(1);
        end
    end

    // The accumulator: clearing wins over adding. The add uses the A value
    // held before this edge, so an ldA on the same edge does not affect it.
    // A*B always fits in 2*WIDTH bits, so the sum cannot overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_reg <= '0;
        end else if (bus.clr_p) begin
            p_reg <= '0;
        end else if (bus.ldP) begin
            p_reg <= p_reg + {{WIDTH{1'b0}}, a_reg};
        end
    end

    // Output holding register. done always captures the newest product.
    // If the previous product is still pending and is not being taken this
    // edge, it is lost and overrun latches until reset. When done coincides
    // with a transfer the old product leaves and the new one replaces it, so
    // valid stays high without flagging an overrun. A transfer without done
    // drops valid but keeps the last value on the result bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_reg  <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else if (bus.done) begin
            result_reg <= p_reg;
            valid_reg  <= 1'b1;
            if (valid_reg && !bus.result_ready) begin
                overrun_reg <= 1'b1;
            end
        end else if (transfer) begin
            valid_reg <= 1'b0;
        end
    end

    assign bus.eqz          = b_is_zero;
    assign bus.result       = result_reg;
    assign bus.result_valid = valid_reg;
    assign bus.overrun      = overrun_reg;

endmodule

// File: tb/tb_mul_datapath.sv
// ---------------------------------------------------------------------------
// tb_mul_datapath
// Self-checking bench for mul_datapath. It plays the role of the control FSM
// and of the downstream consumer. Expected products are computed from the
// operands and pushed to a scoreboard queue when done is driven; the front
// entry is compared against the result bus while the product is pending and
// popped when the consumer takes it.
// ---------------------------------------------------------------------------
module tb_mul_datapath;

    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mul_datapath_if #(.WIDTH(WIDTH)) bus ();

    mul_datapath #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    // Scoreboard and reference state for the output handshake
    logic [2*WIDTH-1:0] sbQueue[$];
    bit                 modelValid;
    bit                 modelOverrun;
    logic [2*WIDTH-1:0] modelResult;
    logic [2*WIDTH-1:0] expProduct;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic clearStrobes();
        bus.ldA   = 1'b0;
        bus.ldB   = 1'b0;
        bus.ldP   = 1'b0;
        bus.clr_p = 1'b0;
        bus.decre = 1'b0;
        bus.done  = 1'b0;
    endtask

    task automatic resetModel();
        sbQueue.delete();
        modelValid   = 1'b0;
        modelOverrun = 1'b0;
        modelResult  = '0;
    endtask

    // Advance one clock. The handshake model is stepped with the inputs that
    // the DUT samples on this edge, then the outputs are checked 1 time unit
    // after the edge.
    task automatic tick();
        bit transfer;
        transfer = modelValid && (bus.result_ready === 1'b1);
        if (bus.done) begin
            if (modelValid && !transfer) begin
                sbQueue[sbQueue.size()-1] = expProduct;
                modelOverrun = 1'b1;
            end else begin
                if (transfer) begin
                    void'(sbQueue.pop_front());
                end
                sbQueue.push_back(expProduct);
            end
            modelValid  = 1'b1;
            modelResult = expProduct;
        end else if (transfer) begin
            void'(sbQueue.pop_front());
            modelValid = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput("resultValid", bus.result_valid, modelValid);
        checkOutput("overrun", bus.overrun, modelOverrun);
        if (modelValid) begin
            checkOutput("result", bus.result, sbQueue[0]);
        end else begin
            checkOutput("resultHeld", bus.result, modelResult);
        end
    endtask

    // One complete multiplication as the control FSM would sequence it.
    // extraLdP / extraDecre add a conflicting strobe to the load cycles,
    // skipLdA omits the A load and accumulator clear, and readyDone is the
    // consumer ready level presented in the done cycle.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input bit extraLdP, input bit extraDecre,
                                 input bit skipLdA, input bit readyDone);
        int iters;
        iters = 0;
        if (!skipLdA) begin
            bus.data_in = a;
            bus.ldA     = 1'b1;
            bus.clr_p   = 1'b1;
            bus.ldP     = extraLdP;
            tick();
            clearStrobes();
        end
        bus.data_in = b;
        bus.ldB     = 1'b1;
        bus.decre   = extraDecre;
        tick();
        clearStrobes();
        checkOutput("eqzAfterLdB", bus.eqz, (b == '0));
        while (!bus.eqz && iters <= int'(b)) begin
            bus.ldP   = 1'b1;
            bus.decre = 1'b1;
            tick();
            iters++;
        end
        clearStrobes();
        checkOutput("iterations", iters, b);
        expProduct       = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        bus.done         = 1'b1;
        bus.result_ready = readyDone;
        tick();
        clearStrobes();
    endtask

    initial begin
        reset = 1'b1;
        clearStrobes();
        bus.data_in      = '0;
        bus.result_ready = 1'b1;
        resetModel();
        expProduct = '0;

        // Reset state
        #3;
        checkOutput("resetEqz", bus.eqz, 1'b1);
        checkOutput("resetValid", bus.result_valid, 1'b0);
        checkOutput("resetResult", bus.result, 0);
        checkOutput("resetOverrun", bus.overrun, 1'b0);
        #4;
        reset = 1'b0;

        // Basic 7*5 run, then a zero B operand, then the full-width corner
        $display("[TB] basic runs");
        applyStimulus(16'd7, 16'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(16'd9, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        // Strobe priority: ldB beats decre, clr_p beats ldP, decre saturates
        $display("[TB] strobe priority");
        applyStimulus(16'd5, 16'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        bus.decre = 1'b1;
        tick();
        tick();
        tick();
        clearStrobes();
        checkOutput("eqzDecreAtZero", bus.eqz, 1'b1);

        // Back-pressure, overwrite and coincident done/transfer
        $display("[TB] handshake");
        bus.result_ready = 1'b0;
        applyStimulus(16'd3, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'd6, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'd5, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.result_ready = 1'b1;
        tick();
        tick();
        bus.result_ready = 1'b0;
        applyStimulus(16'd2, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.result_ready = 1'b0;
        applyStimulus(16'd4, 16'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.result_ready = 1'b0;
        tick();

        // Asynchronous reset in the middle of a 7*3 run (P = 14 partial)
        $display("[TB] reset mid-run");
        bus.data_in = 16'd7;
        bus.ldA     = 1'b1;
        bus.clr_p   = 1'b1;
        tick();
        clearStrobes();
        bus.data_in = 16'd3;
        bus.ldB     = 1'b1;
        tick();
        clearStrobes();
        bus.ldP   = 1'b1;
        bus.decre = 1'b1;
        tick();
        tick();
        clearStrobes();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midResetEqz", bus.eqz, 1'b1);
        checkOutput("midResetValid", bus.result_valid, 1'b0);
        checkOutput("midResetResult", bus.result, 0);
        checkOutput("midResetOverrun", bus.overrun, 1'b0);
        resetModel();
        #1;
        reset = 1'b0;
        bus.result_ready = 1'b1;

        // A and P must both be zero after reset: a run without loading A
        // accumulates nothing.
        applyStimulus(16'd0, 16'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(16'd2, 16'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("scoreboardEmpty", sbQueue.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
